// File: rtl/req_gnt_rr_arbiter_pkg.sv
// Shared types and limits for the round-robin req/gnt arbiter.
package arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

    localparam int MAX_N_REQ = 16;

endpackage

// File: rtl/req_gnt_rr_arbiter_if.sv
// Requester-side bundle for the arbiter: level requests in, registered grant status out.
interface req_gnt_rr_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IW = $clog2(N_REQ);

    // Handshake: req[i] is a level held by requester i for as long as it wants
    // the resource; a req seen while the arbiter is idle is answered by gnt[i]
    // on the following cycle, and gnt[i] stays high until req[i] drops or the
    // hold limit forces release (timeout pulses for that case only).
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_id;
    logic             busy;
    logic             timeout;

    modport master (output req, input gnt, gnt_id, busy, timeout);
    modport slave  (input req, output gnt, gnt_id, busy, timeout);

endinterface

// File: rtl/req_gnt_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start_i, wrapping.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] start_i,
    output logic                     found_o,
    output logic [$clog2(N_REQ)-1:0] winner_o
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off;
    logic [IW:0]      sum;

    // Rotate so start_i lands at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        rot      = '0;
        off      = '0;
        sum      = '0;
        found_o  = 1'b0;
        winner_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, start_i} + (IW+1)'(i);
            if (sum >= N_W) sum = sum - N_W;
            rot[i] = req_i[sum[IW-1:0]];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = IW'(i);
        end
        found_o = |rot;
        sum = {1'b0, start_i} + {1'b0, off};
        if (sum >= N_W) sum = sum - N_W;
        winner_o = sum[IW-1:0];
    end

endmodule

// File: rtl/req_gnt_rr_arbiter.sv
// Round-robin arbiter: IDLE picks a winner, GRANT holds it up to MAX_HOLD cycles,
// GAP forces one dead cycle before the next arbitration.
module req_gnt_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    req_gnt_rr_arbiter_if.slave bus,
    output arb_state_t state_o
);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > MAX_N_REQ) begin : g_bad_n_req
        $error("N_REQ out of range");
    end

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    id_q, id_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             timeout_q, timeout_d;
    logic             found;
    logic [IW-1:0]    winner;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i    (bus.req),
        .start_i  (ptr_q),
        .found_o  (found),
        .winner_o (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = GRANT;
                    gnt_d         = '0;
                    gnt_d[winner] = 1'b1;
                    id_d          = winner;
                    ptr_d         = (winner == LAST_IDX) ? '0 : winner + IW'(1);
                    hold_d        = HW'(1);
                end
            end
            GRANT: begin
                // A voluntary drop wins over the limit, so no timeout on that cycle.
                if (!bus.req[id_q]) begin
                    state_d = GAP;
                    gnt_d   = '0;
                end else if (hold_q == HOLD_LIMIT) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
                hold_d  = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.busy    = |gnt_q;
    assign bus.timeout = timeout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_req_gnt_rr_arbiter.sv
// Scoreboard bench for req_gnt_rr_arbiter: a behavioural model predicts every cycle.
module tb_req_gnt_rr_arbiter;
    import arb_pkg::*;

    localparam int N  = 4;
    localparam int MH = 16;
    localparam int IW = 2;
    localparam int W  = N + IW + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    req_gnt_rr_arbiter_if #(.N_REQ(N)) bus ();
    arb_state_t state;

    req_gnt_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 = idle, 1 = grant, 2 = gap
    int         m_state, m_owner, m_start, m_hold;
    logic [N-1:0] m_gnt;
    logic         m_to;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] observed();
        return {bus.gnt, bus.gnt_id, bus.busy, bus.timeout, state};
    endfunction

    function automatic logic [W-1:0] model_pack();
        logic [1:0] st;
        logic [IW-1:0] ow;
        st = m_state[1:0];
        ow = m_owner[IW-1:0];
        return {m_gnt, ow, |m_gnt, m_to, st};
    endfunction

    task automatic model_reset();
        m_state = 0; m_owner = 0; m_start = 0; m_hold = 0;
        m_gnt = '0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        bit found;
        m_to  = 1'b0;
        found = 1'b0;
        case (m_state)
            0: begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_start + k) % N;
                    if (!found && r[idx]) begin
                        found   = 1'b1;
                        m_owner = idx;
                        m_start = (idx + 1) % N;
                        m_hold  = 1;
                        m_gnt   = '0;
                        m_gnt[idx] = 1'b1;
                        m_state = 1;
                    end
                end
            end
            1: begin
                if (!r[m_owner]) begin
                    m_gnt = '0; m_state = 2;
                end else if (m_hold == MH) begin
                    m_gnt = '0; m_to = 1'b1; m_state = 2;
                end else begin
                    m_hold++;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    task automatic drive_cycle(input logic [N-1:0] r);
        logic was_idle;
        logic [W-1:0] exp;
        @(negedge clk);
        bus.req  = r;
        was_idle = (state == IDLE) && (|r) && !bus.busy;
        model_step(r);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        check("scoreboard", observed(), exp);
        check("onehot0", $onehot0(bus.gnt), 1);
        if (was_idle) check("req_to_gnt", |bus.gnt, 1);
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        model_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("reset_vals", observed(), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, tos, run;
        logic prev;
        logic g1[20];
        logic t1[20];
        int ids[$];
        int lens[$];
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] r;

        bus.req = '0;

        // Single requester held: 16-cycle grant, one timeout, gap, re-grant
        do_reset();
        repeat (4) drive_cycle(4'b0000);
        for (int j = 0; j < 20; j++) begin
            drive_cycle(4'b0001);
            g1[j] = bus.gnt[0];
            t1[j] = bus.timeout;
        end
        ones = 0; tos = 0;
        for (int j = 0; j < 18; j++) ones += int'(g1[j]);
        for (int j = 0; j < 20; j++) tos += int'(t1[j]);
        check("t1_first_gnt", g1[0], 1);
        check("t1_hold_len", ones, 16);
        check("t1_timeout_at", t1[16], 1);
        check("t1_timeouts", tos, 1);
        check("t1_gap_cycles", g1[16] | g1[17], 0);
        check("t1_regrant", g1[18], 1);

        // All requesting: rotation 0,1,2,3,0 with full-length grants
        do_reset();
        prev = 1'b0; run = 0;
        for (int j = 0; j < 80; j++) begin
            drive_cycle(4'b1111);
            if (bus.busy) begin
                if (!prev) ids.push_back(int'(bus.gnt_id));
                run++;
            end else if (prev) begin
                lens.push_back(run);
                run = 0;
            end
            prev = bus.busy;
        end
        check("t2_grant_count", ids.size(), 5);
        for (int k = 0; k < 5; k++) check("t2_order", (k < ids.size()) ? ids[k] : 99, exp_ids[k]);
        for (int k = 0; k < 4; k++) check("t2_len", (k < lens.size()) ? lens[k] : 0, MH);

        // One-cycle request pulse still gets exactly one grant cycle
        do_reset();
        repeat (3) drive_cycle(4'b0000);
        drive_cycle(4'b0100);
        check("t3_gnt_next", bus.gnt, 4'b0100);
        ones = int'(bus.gnt[2]); tos = int'(bus.timeout);
        for (int j = 0; j < 4; j++) begin
            drive_cycle(4'b0000);
            ones += int'(bus.gnt[2]);
            tos  += int'(bus.timeout);
        end
        check("t3_gnt_len", ones, 1);
        check("t3_no_timeout", tos, 0);

        // Owner drops on the MAX_HOLD-th grant cycle: normal release
        do_reset();
        ones = 0; tos = 0;
        for (int j = 0; j < 20; j++) begin
            drive_cycle((j < 16) ? 4'b0010 : 4'b0000);
            ones += int'(bus.gnt[1]);
            tos  += int'(bus.timeout);
        end
        check("t4_gnt_len", ones, 16);
        check("t4_no_timeout", tos, 0);

        // Asynchronous reset in the middle of a grant
        do_reset();
        repeat (5) drive_cycle(4'b1111);
        check("t5_pre_busy", bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_gnt", bus.gnt, 0);
        check("t5_async_busy", bus.busy, 0);
        check("t5_async_state", state, IDLE);
        model_reset();
        bus.req = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(4'b1000);
        check("t5_gnt3", bus.gnt, 4'b1000);
        check("t5_id3", bus.gnt_id, 3);
        repeat (3) drive_cycle(4'b1000);
        repeat (40) drive_cycle(4'b1111);

        // Random traffic against the model
        do_reset();
        r = '0;
        for (int j = 0; j < 10000; j++) begin
            if ($urandom_range(0, 9) == 0) r = N'($urandom_range(0, 15));
            drive_cycle(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
